// File: rtl/gps_carrier_mix_dump_pkg.sv
// Shared definitions for the GPS carrier mix-and-dump block.
// Holds the datapath widths, the FSM state encoding, the 8-entry cosine
// table and two small helpers: sample decode and table lookup.
package gps_carrier_mix_dump_pkg;

  localparam int ACC_W   = 20;
  localparam int PHASE_W = 32;
  localparam int LEN_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // cos[0..7] = 2,2,1,-1,-2,-2,-1,1 as 3-bit two's complement,
  // entry k in bits [3k+2:3k].
  localparam logic [23:0] COS_TABLE = {
    3'b001,  // 7:  1
    3'b111,  // 6: -1
    3'b110,  // 5: -2
    3'b110,  // 4: -2
    3'b111,  // 3: -1
    3'b001,  // 2:  1
    3'b010,  // 1:  2
    3'b010   // 0:  2
  };

  function automatic logic signed [2:0] cos_lookup(input logic [2:0] idx);
    return $signed(COS_TABLE[idx*3 +: 3]);
  endfunction

  // Sign-magnitude ADC code to two's complement; both zero codes give 0.
  function automatic logic signed [2:0] sample_value(input logic [2:0] adc);
    logic signed [2:0] mag;
    mag = $signed({1'b0, adc[1:0]});
    return adc[2] ? -mag : mag;
  endfunction

endpackage

// File: rtl/gps_carrier_mix_dump_if.sv
// Bus bundle for gps_carrier_mix_dump.
// Inputs to the block: adc3bit, sample_valid, start, stop, fcw, dump_len,
// dump_ack. Outputs: i_dump, q_dump, dump_valid, overrun, busy.
// master = the side that feeds samples/controls, slave = the block itself.
interface gps_carrier_mix_dump_if;
  import gps_carrier_mix_dump_pkg::*;

  logic [2:0]         adc3bit;
  logic               sample_valid;
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] fcw;
  logic [LEN_W-1:0]   dump_len;
  logic               dump_ack;
  logic [ACC_W-1:0]   i_dump;
  logic [ACC_W-1:0]   q_dump;
  logic               dump_valid;
  logic               overrun;
  logic               busy;

  modport master (
    output adc3bit, sample_valid, start, stop, fcw, dump_len, dump_ack,
    input  i_dump, q_dump, dump_valid, overrun, busy
  );

  modport slave (
    input  adc3bit, sample_valid, start, stop, fcw, dump_len, dump_ack,
    output i_dump, q_dump, dump_valid, overrun, busy
  );

endinterface

// File: rtl/gps_carrier_mix_dump_lut.sv
// gps_carrier_lut: combinational 3-bit carrier table.
// Ports: idx (3-bit phase index) -> cos_val, sin_val (signed 3-bit).
// sin[k] is cos[k-2 mod 8], i.e. the cosine delayed by a quarter turn.
module gps_carrier_lut
  import gps_carrier_mix_dump_pkg::*;
(
  input  logic [2:0]        idx,
  output logic signed [2:0] cos_val,
  output logic signed [2:0] sin_val
);

  assign cos_val = cos_lookup(idx);
  assign sin_val = cos_lookup(idx - 3'd2);

endmodule

// File: rtl/gps_carrier_mix_dump.sv
// gps_carrier_mix_dump: wipes the carrier off 3-bit ADC samples with an
// NCO-driven LUT and integrates I/Q over dump_len samples.
// Ports: clk, reset (async, active-low), bus (gps_carrier_mix_dump_if.slave)
//   carrying the sample/control inputs and the dump result/status outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | samples ignored, waiting for start
// ST_RUN  | integrating accepted samples, dumping every shadow_len
module gps_carrier_mix_dump
  import gps_carrier_mix_dump_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  gps_carrier_mix_dump_if.slave bus
);

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        phase_q;
  logic signed [ACC_W-1:0]   acc_i_q, acc_q_q;
  logic [LEN_W-1:0]          count_q, shadow_len_q;
  logic [ACC_W-1:0]          i_dump_q, q_dump_q;
  logic                      dump_valid_q, overrun_q;

  logic [2:0]                lut_idx;
  logic signed [2:0]         cos_v, sin_v, sample_v;
  logic signed [3:0]         prod_i4, prod_q4;
  logic signed [ACC_W-1:0]   prod_i, prod_q, sum_i, sum_q;
  logic                      accept, dump_hit, dump_evt;

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start)     state_d = ST_RUN;   // start wins over stop
    else if (bus.stop) state_d = ST_IDLE;
  end

  // Mixer
  assign lut_idx = phase_q[PHASE_W-1 -: 3];

  gps_carrier_lut u_lut (
    .idx     (lut_idx),
    .cos_val (cos_v),
    .sin_val (sin_v)
  );

  assign sample_v = sample_value(bus.adc3bit);
  // |product| <= 6, so a 4-bit signed product is exact.
  assign prod_i4 = $signed({sample_v[2], sample_v}) * $signed({cos_v[2], cos_v});
  assign prod_q4 = $signed({sample_v[2], sample_v}) * $signed({sin_v[2], sin_v});
  assign prod_i  = {{(ACC_W-4){prod_i4[3]}}, prod_i4};
  assign prod_q  = {{(ACC_W-4){prod_q4[3]}}, prod_q4};
  assign sum_i   = acc_i_q + prod_i;
  assign sum_q   = acc_q_q + prod_q;

  // A sample arriving with start/stop is dropped: the run is being reset.
  assign accept   = (state_q == ST_RUN) && bus.sample_valid && !bus.start && !bus.stop;
  // shadow_len of 0 wraps to 16'hFFFF, giving a 65536-sample integration.
  assign dump_hit = (count_q == shadow_len_q - LEN_W'(1));
  assign dump_evt = accept && dump_hit;

  // Integrator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q      <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      count_q      <= '0;
      shadow_len_q <= '0;
    end else if (bus.start) begin
      phase_q      <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      count_q      <= '0;
      shadow_len_q <= bus.dump_len;
    end else if (bus.stop) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      count_q <= '0;
    end else if (accept) begin
      phase_q <= phase_q + bus.fcw;
      if (dump_hit) begin
        acc_i_q      <= '0;
        acc_q_q      <= '0;
        count_q      <= '0;
        shadow_len_q <= bus.dump_len;
      end else begin
        acc_i_q <= sum_i;
        acc_q_q <= sum_q;
        count_q <= count_q + LEN_W'(1);
      end
    end
  end

  // Result registers and handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_dump_q     <= '0;
      q_dump_q     <= '0;
      dump_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (dump_evt) begin
        i_dump_q     <= sum_i;
        q_dump_q     <= sum_q;
        dump_valid_q <= 1'b1;
      end else if (bus.dump_ack) begin
        dump_valid_q <= 1'b0;
      end

      if (bus.start)
        overrun_q <= 1'b0;
      else if (dump_evt && dump_valid_q && !bus.dump_ack)
        overrun_q <= 1'b1;
    end
  end

  assign bus.i_dump     = i_dump_q;
  assign bus.q_dump     = q_dump_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_gps_carrier_mix_dump.sv
// Self-checking bench for gps_carrier_mix_dump: directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a sample-counting reference model.
module tb_gps_carrier_mix_dump;

  logic clk = 1'b0;
  logic reset = 1'b0;

  gps_carrier_mix_dump_if bus ();

  gps_carrier_mix_dump dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: run flag, phase, running sums, samples seen so far.
  int          cos_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  bit          m_run;
  int unsigned m_phase;
  int          m_ai, m_aq, m_seen, m_len;
  int          m_id, m_qd;
  bit          m_dv, m_ov;

  function automatic void model_reset();
    m_run = 0; m_phase = 0; m_ai = 0; m_aq = 0; m_seen = 0; m_len = 65536;
    m_id = 0; m_qd = 0; m_dv = 0; m_ov = 0;
  endfunction

  function automatic void model_edge(bit st, bit sp, bit sv, logic [2:0] adc,
                                     logic [31:0] f, logic [15:0] dl, bit ack);
    bit dump;
    int v, k, ci, cq;
    dump = 0;
    if (st) begin
      m_run = 1; m_phase = 0; m_ai = 0; m_aq = 0; m_seen = 0; m_ov = 0;
      m_len = (dl == 0) ? 65536 : int'(dl);
    end else if (sp) begin
      m_run = 0; m_ai = 0; m_aq = 0; m_seen = 0;
    end else if (m_run && sv) begin
      v = int'(adc[1:0]);
      if (adc[2]) v = -v;
      k = int'(m_phase >> 29);
      ci = v * cos_t[k];
      cq = v * cos_t[(k + 6) % 8];
      m_phase = m_phase + f;
      m_seen++;
      if (m_seen == m_len) begin
        dump = 1;
        m_id = m_ai + ci; m_qd = m_aq + cq;
        m_ai = 0; m_aq = 0; m_seen = 0;
        m_len = (dl == 0) ? 65536 : int'(dl);
      end else begin
        m_ai += ci; m_aq += cq;
      end
    end
    if (dump) begin
      if (m_dv && !ack) m_ov = 1;
      m_dv = 1;
    end else if (ack) begin
      m_dv = 0;
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("i_dump", int'($signed(bus.i_dump)), m_id);
    chk("q_dump", int'($signed(bus.q_dump)), m_qd);
    chk("dump_valid", int'(bus.dump_valid), int'(m_dv));
    chk("overrun", int'(bus.overrun), int'(m_ov));
    chk("busy", int'(bus.busy), int'(m_run));
  endtask

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic drive(bit st, bit sp, bit sv, logic [2:0] adc,
                       logic [31:0] f, logic [15:0] dl, bit ack);
    bus.start = st; bus.stop = sp; bus.sample_valid = sv; bus.adc3bit = adc;
    bus.fcw = f; bus.dump_len = dl; bus.dump_ack = ack;
    model_edge(st, sp, sv, adc, f, dl, ack);
    @(posedge clk);
    #1;
    chk_model();
  endtask

  typedef struct {
    string       name;
    logic [31:0] fcw;
    int          len;
    logic [2:0]  adc;
    bit          alt;
    int          exp_i;
    int          exp_q;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"dc_pos",      32'h0000_0000, 4, 3'b011, 1'b0,  24, -12};
    vecs[1] = '{"full_turn",   32'h2000_0000, 8, 3'b001, 1'b0,   0,   0};
    vecs[2] = '{"dc_neg_alt",  32'h0000_0000, 4, 3'b111, 1'b1, -24,  12};
    vecs[3] = '{"step_up",     32'h2000_0000, 3, 3'b010, 1'b0,  10,   4};
    vecs[4] = '{"step_down",   32'hE000_0000, 3, 3'b101, 1'b1,  -2,   5};

    bus.start = 0; bus.stop = 0; bus.sample_valid = 0; bus.adc3bit = 0;
    bus.fcw = 0; bus.dump_len = 0; bus.dump_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_dump", int'(bus.i_dump), 0);
    chk("rst_q_dump", int'(bus.q_dump), 0);
    chk("rst_dump_valid", int'(bus.dump_valid), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b1;

    // Samples in IDLE are ignored.
    repeat (3) drive(0, 0, 1, 3'b011, 32'h0, 16'd1, 0);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      drive(0, 0, 0, 3'b000, vecs[v].fcw, 16'(vecs[v].len), 1);
      drive(1, 0, 0, 3'b000, vecs[v].fcw, 16'(vecs[v].len), 0);
      for (int s = 0; s < vecs[v].len; s++) begin
        if (vecs[v].alt) drive(0, 0, 0, vecs[v].adc, vecs[v].fcw, 16'(vecs[v].len), 0);
        if (s == vecs[v].len - 1)
          chk({vecs[v].name, "_early_valid"}, int'(bus.dump_valid), 0);
        drive(0, 0, 1, vecs[v].adc, vecs[v].fcw, 16'(vecs[v].len), 0);
      end
      chk({vecs[v].name, "_i"}, int'($signed(bus.i_dump)), vecs[v].exp_i);
      chk({vecs[v].name, "_q"}, int'($signed(bus.q_dump)), vecs[v].exp_q);
      chk({vecs[v].name, "_valid"}, int'(bus.dump_valid), 1);
    end

    // Length 1, no ack: overrun on the 2nd dump, cleared by start.
    drive(0, 0, 0, 3'b000, 32'h0, 16'd1, 1);
    drive(1, 0, 0, 3'b000, 32'h0, 16'd1, 0);
    drive(0, 0, 1, 3'b001, 32'h0, 16'd1, 0);
    chk("len1_valid_1st", int'(bus.dump_valid), 1);
    chk("len1_ovr_1st", int'(bus.overrun), 0);
    drive(0, 0, 1, 3'b001, 32'h0, 16'd1, 0);
    chk("len1_ovr_2nd", int'(bus.overrun), 1);
    drive(1, 0, 0, 3'b000, 32'h0, 16'd1, 0);
    chk("start_clears_ovr", int'(bus.overrun), 0);

    // Length 1 with ack held: valid stays up, no overrun.
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 3'b010, 32'h1234_5678, 16'd1, 1);
      chk("ack_held_valid", int'(bus.dump_valid), 1);
      chk("ack_held_ovr", int'(bus.overrun), 0);
    end

    // Start and stop together: start wins.
    drive(0, 0, 0, 3'b000, 32'h0, 16'd4, 1);
    drive(1, 1, 0, 3'b000, 32'h0, 16'd4, 0);
    chk("start_over_stop", int'(bus.busy), 1);

    // Stop mid-integration, then restart.
    drive(0, 0, 1, 3'b011, 32'h0, 16'd4, 0);
    drive(0, 0, 1, 3'b011, 32'h0, 16'd4, 0);
    drive(0, 1, 0, 3'b000, 32'h0, 16'd4, 0);
    chk("stop_idle", int'(bus.busy), 0);
    drive(1, 0, 0, 3'b000, 32'h0, 16'd4, 0);
    repeat (4) drive(0, 0, 1, 3'b001, 32'h0, 16'd4, 0);
    chk("after_stop_i", int'($signed(bus.i_dump)), 8);
    chk("after_stop_q", int'($signed(bus.q_dump)), -4);

    // Reset mid-integration: asynchronous clear, then stay IDLE until start.
    drive(1, 0, 0, 3'b000, 32'h0, 16'd4, 0);
    drive(0, 0, 1, 3'b011, 32'h0, 16'd4, 0);
    drive(0, 0, 1, 3'b011, 32'h0, 16'd4, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_i", int'(bus.i_dump), 0);
    chk("async_rst_q", int'(bus.q_dump), 0);
    chk("async_rst_valid", int'(bus.dump_valid), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) drive(0, 0, 1, 3'b011, 32'h0, 16'd4, 0);
    drive(1, 0, 0, 3'b000, 32'h0, 16'd4, 0);
    repeat (4) drive(0, 0, 1, 3'b010, 32'h0, 16'd4, 0);
    chk("after_rst_i", int'($signed(bus.i_dump)), 16);
    chk("after_rst_q", int'($signed(bus.q_dump)), -8);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit          st, sp, sv, ack;
      logic [2:0]  adc;
      logic [31:0] f;
      logic [15:0] dl;
      st  = ($urandom_range(0, 40) == 0);
      sp  = ($urandom_range(0, 90) == 0);
      sv  = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 3) == 0);
      adc = 3'($urandom_range(0, 7));
      f   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {3'($urandom_range(0, 7)), 29'd0};
      dl  = 16'($urandom_range(0, 6));
      drive(st, sp, sv, adc, f, dl, ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_carrier_mix_dump.md
GPS_CARRIER_MIX_DUMP -- requirements
Module: gps_carrier_mix_dump

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on the rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: adc3bit  in  3  sign-magnitude sample; bit2 is the sign (1 = negative), bits[1:0] are the magnitude 0..3.
REQ-004 SHALL provide: sample_valid  in  1  adc3bit is valid this cycle.
REQ-005 SHALL provide: start  in  1  single-cycle pulse; begin a new integration run.
REQ-006 SHALL provide: stop  in  1  single-cycle pulse; abort the run.
REQ-007 SHALL provide: fcw  in  32  carrier NCO phase increment per accepted sample.
REQ-008 SHALL provide: dump_len  in  16  samples per integration; 0 means 65536.
REQ-009 SHALL provide: dump_ack  in  1  consumer has taken i_dump/q_dump.
REQ-010 SHALL provide: i_dump, q_dump  out  20 each  signed two's-complement integration results.
REQ-011 SHALL provide: dump_valid  out  1  i_dump/q_dump hold a new result.
REQ-012 SHALL provide: overrun  out  1  sticky flag: a result was overwritten before it was acknowledged.
REQ-013 SHALL provide: busy  out  1  FSM is in RUN.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and RUN.
REQ-015 IDLE -> RUN on start; RUN -> IDLE on stop; start while in RUN SHALL restart the run.
REQ-016 On start: phase = 0, accumulators = 0, sample count = 0, dump_len captured into a shadow register, overrun cleared.
REQ-017 On stop: accumulators and count SHALL be discarded; outputs and dump_valid are unaffected.
REQ-018 If start and stop are asserted together, start SHALL win.
REQ-019 In IDLE, samples SHALL be ignored.
REQ-020 Sample value = sign ? -mag : mag (range -3..+3); 3'b000 and 3'b100 both contribute 0.
REQ-021 Carrier LUT index = phase[31:29]. cos[0..7] = 2,2,1,-1,-2,-2,-1,1. sin[k] = cos[(k-2) mod 8].
REQ-022 Per accepted sample (RUN and sample_valid): I += value*cos[idx]; Q += value*sin[idx]; phase += fcw (mod 2^32, using the pre-increment idx); count += 1.
REQ-023 fcw SHALL be sampled every accepted sample, so frequency changes take effect immediately.
REQ-024 Dump SHALL occur when an accepted sample arrives with count == shadow_len-1 (16-bit wrap).
REQ-025 On dump: i_dump/q_dump = accumulator plus the current product, registered so they are visible the cycle after the edge that accepted the Nth sample.
REQ-026 On dump: accumulators and count restart at 0, the shadow length reloads from dump_len, and the phase continues without reset.
REQ-027 Accumulators SHALL be 20-bit signed; the worst case of +-393216 fits, so no saturation logic is required.
REQ-028 dump_valid SHALL be set on dump and held until a cycle with dump_ack=1 and no concurrent dump.
REQ-029 A dump while dump_valid=1 and dump_ack=0 SHALL overwrite the outputs and set overrun.
REQ-030 A dump concurrent with dump_ack SHALL keep dump_valid=1 and SHALL NOT set overrun.
REQ-031 dump_ack while dump_valid=0 SHALL be ignored.
REQ-032 busy SHALL equal (state == RUN), registered.

Reset
REQ-033 reset=0 SHALL asynchronously force: state IDLE, phase 0, accumulators 0, count 0, shadow_len 0.
REQ-034 reset=0 SHALL asynchronously force: i_dump 0, q_dump 0, dump_valid 0, overrun 0, busy 0.
REQ-035 Reset asserted mid-run SHALL discard all partial results; after release, the block stays in IDLE until start.

Structure
REQ-036 A shared package SHALL hold: ACC_W=20, PHASE_W=32, LEN_W=16, the cos LUT table, and the IDLE/RUN state encodings.
REQ-037 A combinational sub-module gps_carrier_lut SHALL map a 3-bit index to signed 3-bit cos and sin values.

Verification
REQ-038 fcw=0, dump_len=4, start, then 4 samples of 3'b011 -> i_dump=24, q_dump=-12, dump_valid=1 one cycle after the 4th sample.
REQ-039 fcw=32'h20000000, dump_len=8, 8 samples of 3'b001 -> i_dump=0, q_dump=0; the phase wraps to 0.
REQ-040 fcw=0, dump_len=4, samples of 3'b111 with sample_valid on alternate cycles -> i_dump=-24, q_dump=12, dump only after the 4th valid sample.
REQ-041 dump_len=1, continuous samples, dump_ack=0 -> dump_valid=1 after the 1st sample, overrun=1 after the 2nd; a later start clears overrun.
REQ-042 dump_len=1 with dump_ack held at 1 -> dump_valid stays 1 every cycle and overrun stays 0.
REQ-043 Assert stop, then reset, each mid-integration (after 2 of 4 samples), then start -> the next dump reflects only post-start samples; reset forces all outputs to 0 asynchronously.
